// File: rtl/fp_pkg.sv
// fp_pkg: single-precision field layout, constants and divider FSM states
package fp_pkg;
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_MSB  = 22;
    localparam int MAN_LSB  = 0;
    localparam int EXP_BIAS = 127;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;
    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;
    function automatic logic [31:0] inf_of(input logic s);
        return s ? NEG_INF : POS_INF;
    endfunction
endpackage

// File: rtl/mant_div_step.sv
// mant_div_step: one radix-2 restoring division step (compare, subtract, shift)
module mant_div_step #(
    parameter int W = 15
) (
    input  logic [W-1:0] r,
    input  logic [W-1:0] b,
    output logic [W-1:0] r_next,
    output logic         q_bit
);
    // remainder stays below 2*b, so the shifted-out MSB is always zero
    always_comb begin
        q_bit  = r >= b;
        r_next = (q_bit ? r - b : r) << 1;
    end
endmodule

// File: rtl/float_div_seq.sv
// float_div_seq: sequential truncated-mantissa float divider with valid/ready handshakes
module float_div_seq
    import fp_pkg::*;
#(
    parameter int MAN_BITS = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] result,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int W  = MAN_BITS + 1;
    localparam int CW = $clog2(MAN_BITS + 2);

    state_t               state;
    logic                 sign;
    logic [7:0]           e1, e2;
    logic [W-1:0]         rem, div_b, quo, rem_next;
    logic                 q_bit;
    logic [CW-1:0]        cnt;
    logic [MAN_BITS-2:0]  q_frac;
    logic [22:0]          frac;
    logic signed [9:0]    exp_n;
    logic [31:0]          packed_res;
    logic                 unused_bits;

    assign unused_bits = ^{num1, num2};

    mant_div_step #(.W(W)) u_step (
        .r      (rem),
        .b      (div_b),
        .r_next (rem_next),
        .q_bit  (q_bit)
    );

    // normalize the quotient and resolve zero/infinity/overflow/underflow
    always_comb begin
        q_frac     = quo[MAN_BITS] ? quo[MAN_BITS-1:1] : quo[MAN_BITS-2:0];
        frac       = 23'(q_frac) << (24 - MAN_BITS);
        exp_n      = 10'(e1) - 10'(e2) + 10'(EXP_BIAS) - 10'(!quo[MAN_BITS]);
        packed_res = e2 == 8'd0         ? inf_of(sign) :
                     e1 == 8'd0         ? {sign, 31'h0} :
                     exp_n >= 10'sd255  ? inf_of(sign) :
                     exp_n <= 10'sd0    ? {sign, 31'h0} :
                                          {sign, exp_n[7:0], frac};
    end

    // control FSM: capture, iterate the divider, pack the result, hold until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            sign      <= 1'b0;
            e1        <= '0;
            e2        <= '0;
            rem       <= '0;
            div_b     <= '0;
            quo       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign     <= num1[SIGN_BIT] ^ num2[SIGN_BIT];
                    e1       <= num1[EXP_MSB:EXP_LSB];
                    e2       <= num2[EXP_MSB:EXP_LSB];
                    rem      <= {2'b01, num1[MAN_MSB -: MAN_BITS-1]};
                    div_b    <= {2'b01, num2[MAN_MSB -: MAN_BITS-1]};
                    quo      <= '0;
                    cnt      <= CW'(MAN_BITS + 1);
                    in_ready <= 1'b0;
                    state    <= DIV;
                end
                DIV: begin
                    rem   <= rem_next;
                    quo   <= {quo[W-2:0], q_bit};
                    cnt   <= cnt - 1'b1;
                    state <= cnt == CW'(1) ? NORM : DIV;
                end
                NORM: begin
                    result    <= packed_res;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_float_div_seq.sv
// tb_float_div_seq: directed vectors against an arithmetic quotient model and scoreboard
module tb_float_div_seq;
    localparam int M = 14;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] num1 = '0, num2 = '0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [31:0] result;
    int          checks = 0, errors = 0;
    logic [31:0] exp_q[$];

    float_div_seq #(.MAN_BITS(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .num1      (num1),
        .num2      (num2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endfunction

    // quotient of the truncated significands, scaled to M-1 fraction bits after normalization
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        int     e1 = int'(a[30:23]);
        int     e2 = int'(b[30:23]);
        int     e;
        logic   s = a[31] ^ b[31];
        longint ma = (longint'(1) << (M - 1)) | longint'(a[22:0] >> (24 - M));
        longint mb = (longint'(1) << (M - 1)) | longint'(b[22:0] >> (24 - M));
        longint f;
        if (e2 == 0) return {s, 8'hFF, 23'h0};
        if (e1 == 0) return {s, 31'h0};
        if (ma >= mb) begin
            e = e1 - e2 + 127;
            f = (ma << (M - 1)) / mb;
        end else begin
            e = e1 - e2 + 126;
            f = (ma << M) / mb;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, e[7:0], 23'((f - (longint'(1) << (M - 1))) << (24 - M))};
    endfunction

    // scoreboard: queue expectations at accepted inputs, check every valid output cycle
    always @(negedge clk) begin
        if (!rst_n) exp_q.delete();
        else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got 0x%08h expected no output", result);
                end else begin
                    chk("sb_result", result, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(num1, num2));
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] req, input int hold);
        int n = 0;
        chk("model_pin", model(a, b), req);
        chk("idle_ready", 32'(in_ready), 32'd1);
        num1 = a;
        num2 = b;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && n < 100) begin
            chk("busy_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(M + 2));
        chk("result", result, req);
        for (int i = 0; i < hold; i++) begin
            num1 = 32'h3F80_0000;
            num2 = 32'h3F80_0000;
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk("bp_result", result, req);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("drop_valid", 32'(out_valid), 32'd0);
        chk("ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0);
        run_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_A800, 0);
        run_op(32'hC080_0000, 32'h3F00_0000, 32'hC100_0000, 0);
        run_op(32'h3FC0_0000, 32'h3FA0_0000, 32'h3F99_9800, 0);
        run_op(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 0);
        run_op(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 0);
        run_op(32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 0);
        run_op(32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 0);
        run_op(32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 0);
        run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 10);
        num1 = 32'h3F80_0000;
        num2 = 32'h4040_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_result", result, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0);
        repeat (3) @(posedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/float_div_seq.md
# float_div_seq

Sequential single-precision float divider: result = num1 / num2. It is the inverse companion of the truncated-mantissa float multiplier in the FFT datapath, and uses the same precision truncation so that multiply-then-divide paths stay numerically consistent. It uses a radix-2 restoring mantissa divider, one quotient bit per cycle. A valid/ready handshake sits on each side.

## Interface
- MAN_BITS, default 14: mantissa precision including the hidden 1. Legal range 4..24. Divider operands use `{1, man[22:24-MAN_BITS]}`.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- num1  in  32  dividend, IEEE-754 single
- num2  in  32  divisor, IEEE-754 single
- in_valid  in  1  operands present
- in_ready  out  1  block idle, accepts operands; reset 1
- result  out  32  quotient; reset 0x00000000; held stable while out_valid=1
- out_valid  out  1  result available; reset 0
- out_ready  in  1  consumer accepts result

## Operation
- States: IDLE, DIV, NORM, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture sign s=num1[31]^num2[31], e1, e2, A, B.
  - Load remainder R=A (MAN_BITS+1 bits wide), clear quotient Q, set iteration counter to MAN_BITS+1, go to DIV.
- DIV: each cycle,
  - if R>=B: shift 1 into Q and set R=R-B; else shift 0 into Q;
  - then R=R<<1; decrement the counter.
  - After MAN_BITS+1 iterations, go to NORM. Q then holds floor(A·2^MAN_BITS/B) as MAN_BITS+1 bits.
- NORM: form result, go to DONE.
  - Mantissa, Q[MAN_BITS]=1 (A>=B): fraction = Q[MAN_BITS-1:1], biased exponent E = e1−e2+127.
  - Mantissa, Q[MAN_BITS]=0: fraction = Q[MAN_BITS-2:0], E = e1−e2+126.
  - Fraction (MAN_BITS−1 bits) is left-aligned into result[22:0]; low bits are zero. Truncate only, no rounding.
  - Exponent arithmetic is 10-bit signed.
- Special cases, in priority order (sign = s in every case):
  1. e2==0: result = {s, 8'hFF, 23'h0} (infinity). 0/0 also yields infinity.
  2. e1==0: result = {s, 31'h0}.
  3. E>=255: result = {s, 8'hFF, 23'h0}.
  4. E<=0: result = {s, 31'h0}.
  - Denormals are treated as zero. NaN/Inf inputs are not detected; their exponent field is used as-is.
  - Special cases do not shorten latency. DIV always runs the full iteration count.
- DONE:
  - out_valid=1, result held.
  - On out_ready, go to IDLE and drop out_valid.
  - in_ready is 0 in DIV, NORM and DONE.

## Timing
- Latency: with operands captured at edge 0, out_valid rises after edge MAN_BITS+2 (16 cycles at the default).
- Throughput: one operation per MAN_BITS+4 cycles when out_ready is held high. There is no overlap of operations.
- in_valid while in_ready=0 is ignored, not queued.
- out_ready while out_valid=0 is ignored.
- Back-pressure: DONE is held indefinitely, and result must not change.
- Asynchronous reset mid-operation returns to IDLE immediately. All outputs take their reset values and the partial result is discarded.
- The operation capture in IDLE and the return from DONE cannot coincide, since each is in a separate state.

## Structure
- Shared package (fp_pkg):
  - field widths and bit positions: SIGN_BIT, EXP_MSB/LSB, MAN_MSB/LSB;
  - EXP_BIAS=127;
  - constants POS_INF/NEG_INF;
  - state enum {IDLE, DIV, NORM, DONE}.
- One sub-module, mant_div_step: combinational single restoring step. Inputs R and B; outputs next R and the quotient bit.
- The control FSM, counter and special-case logic live in the top module.

## Test plan
- 0x40C00000 (6.0) / 0x40000000 (2.0) -> 0x40400000 after 16 cycles. in_ready low throughout.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAA800, exercising the A<B normalize path with truncation. Also 0xC0800000 / 0x3F000000 -> 0xC1000000.
- 0x3F800000 / 0x00000000 -> 0x7F800000. 0xBF800000 / 0x00000000 -> 0xFF800000. 0x00000000 / 0x40000000 -> 0x00000000.
- Overflow: 0x7F000000 / 0x3E800000 -> 0x7F800000. Underflow: 0x00800000 / 0x40000000 -> 0x00000000.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid. Result stays stable and a new in_valid is ignored. Releasing out_ready gives in_ready=1 on the next cycle.
- Reset: assert rst_n=0 at cycle 8 of an operation. in_ready=1, out_valid=0 and result=0 immediately. A subsequent 6.0/2.0 still gives 0x40400000.
